// File: rtl/rle_pkg.sv
// Shared widths, run-word layout and buffer occupancy states for the RLE pixel decoder.
package rle_pkg;

    localparam int LEN_BITS    = 10;
    localparam int COLOUR_BITS = 6;
    localparam int RUN_W       = LEN_BITS + COLOUR_BITS;

    typedef struct packed {
        logic [LEN_BITS-1:0]    len;
        logic [COLOUR_BITS-1:0] colour;
    } run_t;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } buf_state_e;

endpackage

// File: rtl/rle_run_buffer.sv
// Two-entry current/next run holding stage; the next slot lets a 1-pixel run be replaced
// every clock without a bubble.
module rle_run_buffer
    import rle_pkg::*;
#(
    parameter int W = RUN_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         accept,
    input  logic         vacate,
    input  logic         flush,
    input  logic [W-1:0] in_run,
    output logic         cur_valid,
    output logic [W-1:0] cur_run,
    output logic         full,
    output logic         cur_load,
    output logic [W-1:0] load_run
);

    buf_state_e   state_q, state_d;
    logic [W-1:0] cur_run_q, cur_run_d;
    logic [W-1:0] nxt_run_q, nxt_run_d;
    logic         cur_free;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= EMPTY;
            cur_run_q <= '0;
            nxt_run_q <= '0;
        end else begin
            state_q   <= state_d;
            cur_run_q <= cur_run_d;
            nxt_run_q <= nxt_run_d;
        end
    end

    // An incoming word goes to current only if current ends up with nothing else to hold.
    always_comb begin
        state_d   = state_q;
        cur_run_d = cur_run_q;
        nxt_run_d = nxt_run_q;
        cur_free  = (state_q == EMPTY) || (vacate && (state_q == ONE));

        if (vacate) begin
            cur_run_d = nxt_run_q;
        end
        if (accept) begin
            if (cur_free) begin
                cur_run_d = in_run;
            end else begin
                nxt_run_d = in_run;
            end
        end

        case (state_q)
            EMPTY:   state_d = accept ? ONE : EMPTY;
            ONE: begin
                if (vacate && !accept) begin
                    state_d = EMPTY;
                end else if (!vacate && accept) begin
                    state_d = TWO;
                end else begin
                    state_d = ONE;
                end
            end
            TWO:     state_d = (vacate && !accept) ? ONE : TWO;
            default: state_d = EMPTY;
        endcase

        if (flush) begin
            state_d = EMPTY;
        end

        cur_load = !flush && ((vacate && (state_q == TWO)) || (accept && cur_free));
        load_run = (accept && cur_free) ? in_run : nxt_run_q;
    end

    assign cur_valid = (state_q != EMPTY);
    assign full      = (state_q == TWO);
    assign cur_run   = cur_run_q;

endmodule

// File: rtl/rle_decoder.sv
// Run-length pixel decoder: expands buffered runs into one registered colour per active pixel,
// re-aligning to the frame on vsync_pulse and flagging pixels that found no run.
module rle_decoder #(
    parameter int LEN_BITS    = rle_pkg::LEN_BITS,
    parameter int COLOUR_BITS = rle_pkg::COLOUR_BITS
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [LEN_BITS+COLOUR_BITS-1:0] run_data,
    input  logic                            run_valid,
    output logic                            run_ready,
    input  logic                            blank,
    input  logic                            vsync_pulse,
    output logic [COLOUR_BITS-1:0]          rgb,
    output logic                            underflow
);

    localparam int W = LEN_BITS + COLOUR_BITS;

    logic                   cur_valid, full, cur_load;
    logic [W-1:0]           cur_run, load_run;
    logic                   consume, vacate, accept;
    logic [LEN_BITS-1:0]    count_q, count_d;
    logic [COLOUR_BITS-1:0] rgb_q, rgb_d;
    logic                   underflow_q, underflow_d;

    assign run_ready = !full && !vsync_pulse && !reset;

    rle_run_buffer #(
        .W(W)
    ) u_buffer (
        .clk      (clk),
        .reset    (reset),
        .accept   (accept),
        .vacate   (vacate),
        .flush    (vsync_pulse),
        .in_run   (run_data),
        .cur_valid(cur_valid),
        .cur_run  (cur_run),
        .full     (full),
        .cur_load (cur_load),
        .load_run (load_run)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q     <= '0;
            rgb_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            rgb_q       <= rgb_d;
            underflow_q <= underflow_d;
        end
    end

    // A word arriving into an empty buffer is not usable until the next clock, so it never feeds a pixel here.
    always_comb begin
        accept  = run_valid && run_ready;
        consume = cur_valid && !blank && !vsync_pulse;
        vacate  = consume && (count_q == '0);

        count_d = count_q;
        if (vsync_pulse) begin
            count_d = '0;
        end else if (cur_load) begin
            count_d = load_run[W-1:COLOUR_BITS];
        end else if (consume && (count_q != '0)) begin
            count_d = count_q - LEN_BITS'(1);
        end

        rgb_d = consume ? cur_run[COLOUR_BITS-1:0] : '0;

        underflow_d = underflow_q;
        if (!blank && !cur_valid) begin
            underflow_d = 1'b1;
        end
        if (vsync_pulse) begin
            underflow_d = 1'b0;
        end
    end

    assign rgb       = rgb_q;
    assign underflow = underflow_q;

endmodule
